voice_allocator: RTL and testbench



---
 rtl/voice_allocator.sv | 207 ++++++++++++++++++++
 tb/tb_voice_allocator.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic voice scheduler. Assigns note events to voice
// slots by held-note reuse, lowest free voice, or stealing the oldest voice.
module voice_allocator #(
    parameter int unsigned NBVOICE    = 6,
    parameter int unsigned RETRIG_GAP = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ev_valid,
    output logic                   ev_ready,
    input  logic                   ev_on,
    input  logic [6:0]             ev_note,
    input  logic [6:0]             ev_velo,
    input  logic                   all_off,
    output logic [NBVOICE-1:0]     trig_out,
    output logic [NBVOICE*7-1:0]   note_out,
    output logic [NBVOICE*7-1:0]   velo_out,
    output logic                   steal_out
);

    localparam int unsigned IDXW = $clog2(NBVOICE);
    localparam int unsigned GAPW = $clog2(RETRIG_GAP + 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DECIDE, S_GAP} state_t;

    typedef struct packed {
        logic       on;
        logic [6:0] note;
        logic [6:0] velo;
    } ev_t;

    state_t              state_q, state_d;
    logic [IDXW-1:0]     idx_q, idx_d;
    ev_t                 ev_q, ev_d;
    logic                match_vld_q, match_vld_d;
    logic [IDXW-1:0]     match_idx_q, match_idx_d;
    logic                free_vld_q, free_vld_d;
    logic [IDXW-1:0]     free_idx_q, free_idx_d;
    logic [IDXW-1:0]     old_idx_q, old_idx_d;
    logic [IDXW-1:0]     tgt_q, tgt_d;
    logic [GAPW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [NBVOICE-1:0]  gate_q, gate_d;
    logic [6:0]          note_q [NBVOICE];
    logic [6:0]          note_d [NBVOICE];
    logic [6:0]          velo_q [NBVOICE];
    logic [6:0]          velo_d [NBVOICE];
    logic [IDXW-1:0]     rank_q [NBVOICE];
    logic [IDXW-1:0]     rank_d [NBVOICE];
    logic                steal_q, steal_d;
    logic                ready_q, ready_d;

    logic [IDXW-1:0]     pick_c;
    logic                note_on_c;

    // Voice chosen at DECIDE for a note-on: match, else lowest free, else oldest
    always_comb begin
        pick_c = old_idx_q;
        if (match_vld_q) begin
            pick_c = match_idx_q;
        end else if (free_vld_q) begin
            pick_c = free_idx_q;
        end
        note_on_c = ev_q.on && (ev_q.velo != 7'd0);
    end

    // Next-state and voice-table update
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        ev_d        = ev_q;
        match_vld_d = match_vld_q;
        match_idx_d = match_idx_q;
        free_vld_d  = free_vld_q;
        free_idx_d  = free_idx_q;
        old_idx_d   = old_idx_q;
        tgt_d       = tgt_q;
        gap_cnt_d   = gap_cnt_q;
        gate_d      = gate_q;
        note_d      = note_q;
        velo_d      = velo_q;
        rank_d      = rank_q;
        steal_d     = 1'b0;

        if (all_off) begin
            gate_d    = '0;
            state_d   = S_IDLE;
            gap_cnt_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ev_valid) begin
                        ev_d        = '{on: ev_on, note: ev_note, velo: ev_velo};
                        idx_d       = '0;
                        match_vld_d = 1'b0;
                        free_vld_d  = 1'b0;
                        state_d     = S_SCAN;
                    end
                end
                S_SCAN: begin
                    if (gate_q[idx_q] && (note_q[idx_q] == ev_q.note) && !match_vld_q) begin
                        match_vld_d = 1'b1;
                        match_idx_d = idx_q;
                    end
                    if (!gate_q[idx_q] && !free_vld_q) begin
                        free_vld_d = 1'b1;
                        free_idx_d = idx_q;
                    end
                    if (rank_q[idx_q] == IDXW'(NBVOICE - 1)) begin
                        old_idx_d = idx_q;
                    end
                    if (idx_q == IDXW'(NBVOICE - 1)) begin
                        state_d = S_DECIDE;
                    end else begin
                        idx_d = idx_q + IDXW'(1);
                    end
                end
                S_DECIDE: begin
                    state_d = S_IDLE;
                    if (note_on_c) begin
                        note_d[pick_c] = ev_q.note;
                        velo_d[pick_c] = ev_q.velo;
                        if (match_vld_q || !free_vld_q) begin
                            gate_d[pick_c] = 1'b0;
                            tgt_d          = pick_c;
                            gap_cnt_d      = '0;
                            steal_d        = !match_vld_q;
                            state_d        = S_GAP;
                        end else begin
                            gate_d[pick_c] = 1'b1;
                        end
                        for (int i = 0; i < NBVOICE; i++) begin
                            if (IDXW'(i) == pick_c) begin
                                rank_d[i] = '0;
                            end else if (rank_q[i] < rank_q[pick_c]) begin
                                rank_d[i] = rank_q[i] + IDXW'(1);
                            end
                        end
                    end else if (match_vld_q) begin
                        gate_d[match_idx_q] = 1'b0;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GAPW'(RETRIG_GAP - 1)) begin
                        gate_d[tgt_q] = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        gap_cnt_d = gap_cnt_q + GAPW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        ready_d = (state_d == S_IDLE);
    end

    // State and voice-table registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            ev_q        <= '0;
            match_vld_q <= 1'b0;
            match_idx_q <= '0;
            free_vld_q  <= 1'b0;
            free_idx_q  <= '0;
            old_idx_q   <= '0;
            tgt_q       <= '0;
            gap_cnt_q   <= '0;
            gate_q      <= '0;
            steal_q     <= 1'b0;
            ready_q     <= 1'b1;
            for (int i = 0; i < NBVOICE; i++) begin
                note_q[i] <= '0;
                velo_q[i] <= '0;
                rank_q[i] <= IDXW'(i);
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            ev_q        <= ev_d;
            match_vld_q <= match_vld_d;
            match_idx_q <= match_idx_d;
            free_vld_q  <= free_vld_d;
            free_idx_q  <= free_idx_d;
            old_idx_q   <= old_idx_d;
            tgt_q       <= tgt_d;
            gap_cnt_q   <= gap_cnt_d;
            gate_q      <= gate_d;
            steal_q     <= steal_d;
            ready_q     <= ready_d;
            note_q      <= note_d;
            velo_q      <= velo_d;
            rank_q      <= rank_d;
        end
    end

    // Flatten per-voice registers onto the output buses
    for (genvar g = 0; g < NBVOICE; g++) begin : g_out
        assign note_out[7*g +: 7] = note_q[g];
        assign velo_out[7*g +: 7] = velo_q[g];
    end

    assign trig_out  = gate_q;
    assign steal_out = steal_q;
    assign ev_ready  = ready_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed scenarios then random events, checked
// against a voice-table reference model.
module tb_voice_allocator;

    localparam int NB = 6;
    localparam int RG = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            ev_valid = 1'b0;
    logic            ev_ready;
    logic            ev_on = 1'b0;
    logic [6:0]      ev_note = '0;
    logic [6:0]      ev_velo = '0;
    logic            all_off = 1'b0;
    logic [NB-1:0]   trig_out;
    logic [NB*7-1:0] note_out;
    logic [NB*7-1:0] velo_out;
    logic            steal_out;

    int total = 0;
    int bad   = 0;

    int m_gate [NB];
    int m_note [NB];
    int m_velo [NB];
    int m_rank [NB];

    voice_allocator #(.NBVOICE(NB), .RETRIG_GAP(RG)) dut (
        .clk(clk), .rst_n(rst_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_on(ev_on), .ev_note(ev_note), .ev_velo(ev_velo), .all_off(all_off),
        .trig_out(trig_out), .note_out(note_out), .velo_out(velo_out),
        .steal_out(steal_out)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] exp_trig();
        logic [63:0] r = '0;
        for (int i = 0; i < NB; i++) r[i] = (m_gate[i] != 0);
        return r;
    endfunction

    function automatic logic [63:0] exp_note();
        logic [63:0] r = '0;
        for (int i = 0; i < NB; i++) r[7*i +: 7] = 7'(m_note[i]);
        return r;
    endfunction

    function automatic logic [63:0] exp_velo();
        logic [63:0] r = '0;
        for (int i = 0; i < NB; i++) r[7*i +: 7] = 7'(m_velo[i]);
        return r;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NB; i++) begin
            m_gate[i] = 0; m_note[i] = 0; m_velo[i] = 0; m_rank[i] = i;
        end
    endfunction

    task automatic chk_all(input string tag, input bit exp_steal, input bit exp_ready);
        chk({tag, ".trig"}, 64'(trig_out), exp_trig());
        chk({tag, ".note"}, 64'(note_out), exp_note());
        chk({tag, ".velo"}, 64'(velo_out), exp_velo());
        chk({tag, ".steal"}, 64'(steal_out), 64'(exp_steal));
        chk({tag, ".ready"}, 64'(ev_ready), 64'(exp_ready));
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ev_ready !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        chk("wait_ready", 64'(ev_ready), 64'd1);
    endtask

    // mode: 0 plain, 1 all_off during gap, 2 reset during gap
    task automatic do_event(input bit on, input int note, input int velo, input int mode);
        int  m = -1, f = -1, o = -1, v, r;
        bit  gap = 0, stl = 0;
        wait_ready();
        ev_valid = 1'b1; ev_on = on; ev_note = 7'(note); ev_velo = 7'(velo);
        tick(1);
        ev_valid = 1'b0; ev_on = 1'($urandom); ev_note = 7'($urandom); ev_velo = 7'($urandom);
        tick(NB);
        chk("scan.trig", 64'(trig_out), exp_trig());
        chk("scan.ready", 64'(ev_ready), 64'd0);
        for (int i = NB - 1; i >= 0; i--) begin
            if (m_gate[i] != 0 && m_note[i] == note) m = i;
            if (m_gate[i] == 0) f = i;
            if (m_rank[i] == NB - 1) o = i;
        end
        if (on && velo != 0) begin
            if (m >= 0) begin v = m; gap = 1; end
            else if (f >= 0) v = f;
            else begin v = o; gap = 1; stl = 1; end
            m_note[v] = note; m_velo[v] = velo; m_gate[v] = gap ? 0 : 1;
            r = m_rank[v];
            for (int i = 0; i < NB; i++) if (m_rank[i] < r) m_rank[i]++;
            m_rank[v] = 0;
        end else if (m >= 0) begin
            m_gate[m] = 0;
        end
        tick(1);
        chk_all("decide", stl, !gap);
        if (gap) begin
            if (mode == 1) begin
                all_off = 1'b1; tick(1); all_off = 1'b0;
                for (int i = 0; i < NB; i++) m_gate[i] = 0;
                chk_all("gap_alloff", 0, 1);
            end else if (mode == 2) begin
                rst_n = 1'b0; tick(1); rst_n = 1'b1;
                model_reset();
                chk_all("gap_reset", 0, 1);
            end else begin
                for (int k = 1; k < RG; k++) begin
                    tick(1);
                    chk("gap.trig", 64'(trig_out), exp_trig());
                    chk("gap.ready", 64'(ev_ready), 64'd0);
                end
                tick(1);
                m_gate[v] = 1;
                chk_all("regate", 0, 1);
            end
        end
    endtask

    task automatic scan_abort(input int note);
        wait_ready();
        ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'(note); ev_velo = 7'd99;
        tick(1);
        ev_valid = 1'b0;
        tick(1);
        all_off = 1'b1; tick(1); all_off = 1'b0;
        for (int i = 0; i < NB; i++) m_gate[i] = 0;
        chk_all("scan_alloff", 0, 1);
        tick(NB + 2);
        chk_all("scan_dropped", 0, 1);
    endtask

    initial begin
        model_reset();
        tick(2);
        chk_all("reset", 0, 1);
        rst_n = 1'b1;
        tick(1);

        // Fill all six voices, then steal twice
        for (int n = 60; n <= 65; n++) do_event(1, n, 100, 0);
        do_event(1, 70, 90, 0);
        do_event(1, 71, 80, 0);
        // Retrigger held 62 with new velocity
        do_event(1, 62, 50, 0);
        // Note-off held, note-off unheld, note-on velocity 0 on held
        do_event(0, 62, 0, 0);
        do_event(0, 61, 0, 0);
        do_event(1, 63, 0, 0);
        // Lowest free voice is 2
        do_event(1, 80, 70, 0);
        // Panic during scan and during gap, reset during gap
        scan_abort(90);
        do_event(1, 64, 10, 0);
        do_event(1, 64, 20, 1);
        do_event(1, 65, 30, 0);
        do_event(1, 65, 40, 2);

        // Random events over a narrow note range to force matches and steals
        for (int n = 0; n < 150; n++) begin
            int sel = $urandom_range(0, 24);
            if (sel == 0) begin
                wait_ready();
                all_off = 1'b1; tick(1); all_off = 1'b0;
                for (int i = 0; i < NB; i++) m_gate[i] = 0;
                chk_all("idle_alloff", 0, 1);
            end else begin
                do_event(sel > 7, 60 + $urandom_range(0, 9),
                         ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 127),
                         ($urandom_range(0, 11) == 0) ? 1 : 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
